fetch_queue_unit: RTL and testbench

- Parametrised instruction-fetch front end for the next-generation pipelined 64-bit CPU. It replaces the single-cycle PC register and PC-update logic.
- Owns the fetch PC and issues sequential word requests to a latency-tolerant instruction memory.
- Buffers returned instructions, tagged with their PC, in a DEPTH-entry queue and presents them to decode with a valid/ready handshake.
- Supports redirect (taken branch or exception) with a flush that discards in-flight responses.

---
 rtl/fetch_queue_unit.sv | 160 ++++++++++++++++
 tb/tb_fetch_queue_unit.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue_unit.sv
// Instruction-fetch front end: owns the fetch PC, issues word requests, queues {pc, inst} for decode.
// Latency: a memory response becomes visible on inst_valid the cycle after it arrives (no bypass).
// Backpressure: requests are credit-limited to queue + outstanding + drop < DEPTH; inst_ready stalls the head.

// Small in-order FIFO with flush; push and pop together are legal at any occupancy, including full.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_pop   = pop && (count != '0);
  assign do_push  = push && ((count != CW'(DEPTH)) || do_pop);
  assign pop_data = mem[rd_ptr];

  // Storage needs no reset: entries are only read once the count says they were written.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= push_data;
  end

  // Pointer and count update; flush wins over any push or pop in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end
endmodule

module fetch_queue_unit #(
  parameter int              XLEN     = 64,
  parameter int              ILEN     = 32,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [ILEN-1:0] imem_rsp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [ILEN-1:0] inst_data,
  output logic [XLEN-1:0] inst_pc,
  output logic            rsp_err
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int SW = CW + 2;

  logic [XLEN-1:0]      fetch_pc;
  logic [CW-1:0]        drop;
  logic [CW-1:0]        outstanding;
  logic [CW-1:0]        occupancy;
  logic [XLEN-1:0]      pend_pc;
  logic [XLEN+ILEN-1:0] q_head;
  logic [SW-1:0]        credit_sum;
  logic [CW-1:0]        inflight;
  logic [CW-1:0]        redirect_drop;
  logic                 req_fire;
  logic                 rsp_take;
  logic                 rsp_stray;

  // Every issued-but-unanswered request and every stale response still owed
  // holds a queue slot, so the queue can never be overrun.
  assign credit_sum     = SW'(occupancy) + SW'(outstanding) + SW'(drop);
  assign imem_req_valid = reset && !redirect_valid && (credit_sum < SW'(DEPTH));
  assign imem_req_addr  = fetch_pc;
  assign req_fire       = imem_req_valid && imem_req_ready;

  assign rsp_take  = imem_rsp_valid && !redirect_valid && (drop == '0) && (outstanding != '0);
  assign rsp_stray = imem_rsp_valid && (drop == '0) && (outstanding == '0);

  // On redirect all outstanding requests turn stale; a response landing in that
  // same cycle already pays off one of them.
  assign inflight      = drop + outstanding;
  assign redirect_drop = inflight - CW'(imem_rsp_valid && (inflight != '0));

  assign inst_valid = (occupancy != '0);
  assign inst_pc    = inst_valid ? q_head[XLEN+ILEN-1:ILEN] : '0;
  assign inst_data  = inst_valid ? q_head[ILEN-1:0] : '0;

  // PCs of accepted requests, oldest first; its count is the outstanding counter.
  sync_fifo #(.WIDTH(XLEN), .DEPTH(DEPTH)) u_pending (
    .clk       (clk),
    .rst_n     (reset),
    .flush     (redirect_valid),
    .push      (req_fire),
    .push_data (fetch_pc),
    .pop       (rsp_take),
    .pop_data  (pend_pc),
    .count     (outstanding)
  );

  // Instruction queue presented to decode.
  sync_fifo #(.WIDTH(XLEN + ILEN), .DEPTH(DEPTH)) u_queue (
    .clk       (clk),
    .rst_n     (reset),
    .flush     (redirect_valid),
    .push      (rsp_take),
    .push_data ({pend_pc, imem_rsp_data}),
    .pop       (inst_valid && inst_ready),
    .pop_data  (q_head),
    .count     (occupancy)
  );

  // Fetch PC: redirect target (word aligned) has priority over sequential advance.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_pc <= RESET_PC;
    end else if (redirect_valid) begin
      fetch_pc <= {redirect_pc[XLEN-1:2], 2'b00};
    end else if (req_fire) begin
      fetch_pc <= fetch_pc + XLEN'(4);
    end
  end

  // Stale-response counter and sticky error for responses nobody asked for.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      drop    <= '0;
      rsp_err <= 1'b0;
    end else begin
      if (redirect_valid) begin
        drop <= redirect_drop;
      end else if (imem_rsp_valid && (drop != '0)) begin
        drop <= drop - 1'b1;
      end
      if (rsp_stray) rsp_err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_fetch_queue_unit.sv
module tb_fetch_queue_unit;
  localparam int XLEN  = 64;
  localparam int ILEN  = 32;
  localparam int DEPTH = 4;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_rsp_valid;
  logic [ILEN-1:0] imem_rsp_data;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            inst_valid;
  logic            inst_ready;
  logic [ILEN-1:0] inst_data;
  logic [XLEN-1:0] inst_pc;
  logic            rsp_err;

  always #5 clk = ~clk;

  fetch_queue_unit #(.XLEN(XLEN), .ILEN(ILEN), .DEPTH(DEPTH), .RESET_PC('0)) dut (
    .clk            (clk),
    .reset          (reset),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst_data      (inst_data),
    .inst_pc        (inst_pc),
    .rsp_err        (rsp_err)
  );

  typedef struct packed {
    logic        rdy;
    logic        rv;
    logic [63:0] addr;
    logic        iv;
    logic [63:0] pc;
  } vec_t;

  vec_t        vecs [14];
  int          n_cmp = 0;
  int          n_bad = 0;

  // memory model state
  logic [63:0] mq_addr [$];
  int          mq_due  [$];
  int          cyc;
  int          latency;
  logic        force_rsp;
  logic        acc_now;
  logic [63:0] acc_addr_now;
  logic [63:0] hs_pc [$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mdata(input logic [63:0] a);
    logic [31:0] lo;
    lo = a[31:0];
    return lo * 32'd3 + 32'h1234_5679;
  endfunction

  // Drive the memory response for this cycle, then look at the DUT outputs.
  task automatic sample();
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    if (force_rsp) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = 32'hDEAD_BEEF;
    end else if (mq_addr.size() > 0 && mq_due[0] <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mdata(mq_addr[0]);
      void'(mq_addr.pop_front());
      void'(mq_due.pop_front());
    end
    #1;
    acc_now      = imem_req_valid && imem_req_ready;
    acc_addr_now = imem_req_addr;
    if (acc_now) begin
      mq_addr.push_back(imem_req_addr);
      mq_due.push_back(cyc + latency);
    end
    if (inst_valid && inst_ready) begin
      hs_pc.push_back(inst_pc);
      check("inst_data", inst_data, mdata(inst_pc));
    end
  endtask

  task automatic advance();
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic do_reset();
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    inst_ready     = 1'b0;
    imem_req_ready = 1'b1;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    force_rsp      = 1'b0;
    latency        = 1;
    mq_addr.delete();
    mq_due.delete();
    reset = 1'b1;
    #1;
    reset = 1'b0;
    #1;
    check("rst_req_valid",  imem_req_valid, 0);
    check("rst_req_addr",   imem_req_addr,  0);
    check("rst_inst_valid", inst_valid,     0);
    check("rst_inst_data",  inst_data,      0);
    check("rst_inst_pc",    inst_pc,        0);
    check("rst_rsp_err",    rsp_err,        0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    cyc   = 0;
    hs_pc.delete();
  endtask

  initial begin
    int          n;
    logic        got_first;
    logic [63:0] first_addr;

    // Latency-1 memory, decode stalls for cycles 5..8.
    vecs[0]  = '{1'b1, 1'b1, 64'h00, 1'b0, 64'h00};
    vecs[1]  = '{1'b1, 1'b1, 64'h04, 1'b0, 64'h00};
    vecs[2]  = '{1'b1, 1'b1, 64'h08, 1'b1, 64'h00};
    vecs[3]  = '{1'b1, 1'b1, 64'h0C, 1'b1, 64'h04};
    vecs[4]  = '{1'b1, 1'b1, 64'h10, 1'b1, 64'h08};
    vecs[5]  = '{1'b0, 1'b1, 64'h14, 1'b1, 64'h0C};
    vecs[6]  = '{1'b0, 1'b1, 64'h18, 1'b1, 64'h0C};
    vecs[7]  = '{1'b0, 1'b0, 64'h1C, 1'b1, 64'h0C};
    vecs[8]  = '{1'b0, 1'b0, 64'h1C, 1'b1, 64'h0C};
    vecs[9]  = '{1'b1, 1'b0, 64'h1C, 1'b1, 64'h0C};
    vecs[10] = '{1'b1, 1'b1, 64'h1C, 1'b1, 64'h10};
    vecs[11] = '{1'b1, 1'b1, 64'h20, 1'b1, 64'h14};
    vecs[12] = '{1'b1, 1'b1, 64'h24, 1'b1, 64'h18};
    vecs[13] = '{1'b1, 1'b1, 64'h28, 1'b1, 64'h1C};

    do_reset();
    for (int i = 0; i < 14; i++) begin
      inst_ready = vecs[i].rdy;
      sample();
      check($sformatf("v%0d_req_valid", i),  imem_req_valid, vecs[i].rv);
      check($sformatf("v%0d_req_addr", i),   imem_req_addr,  vecs[i].addr);
      check($sformatf("v%0d_inst_valid", i), inst_valid,     vecs[i].iv);
      check($sformatf("v%0d_inst_pc", i),    inst_pc,        vecs[i].pc);
      advance();
    end

    // Decode stalled from reset: credit stops fetch at four, then drains in order.
    do_reset();
    n = 0;
    for (int i = 0; i < 20; i++) begin
      sample();
      if (acc_now) n++;
      advance();
    end
    sample();
    check("stall_req_count", n, 4);
    check("stall_req_valid", imem_req_valid, 0);
    check("stall_head_pc",   inst_pc, 0);
    advance();
    inst_ready = 1'b1;
    got_first  = 1'b0;
    first_addr = '0;
    for (int i = 0; i < 20; i++) begin
      sample();
      if (acc_now && !got_first) begin
        got_first  = 1'b1;
        first_addr = acc_addr_now;
      end
      advance();
    end
    check("resume_seen", got_first, 1);
    check("resume_addr", first_addr, 64'h10);
    check("drain_count", hs_pc.size() >= 4, 1);
    for (int i = 0; i < 4; i++) begin
      if (i < hs_pc.size()) check($sformatf("drain_pc%0d", i), hs_pc[i], 64'(4 * i));
    end

    // Latency 3, two requests outstanding, redirect to an unaligned target.
    do_reset();
    latency    = 3;
    inst_ready = 1'b1;
    sample(); advance();
    sample(); advance();
    redirect_valid = 1'b1;
    redirect_pc    = 64'h1003;
    sample();
    check("redir_req_valid", imem_req_valid, 0);
    advance();
    redirect_valid = 1'b0;
    sample();
    check("redir_next_valid", imem_req_valid, 1);
    check("redir_next_addr",  imem_req_addr, 64'h1000);
    advance();
    for (int i = 0; i < 15; i++) begin
      sample(); advance();
    end
    check("redir_first_seen", hs_pc.size() > 0, 1);
    if (hs_pc.size() > 0) check("redir_first_pc", hs_pc[0], 64'h1000);

    // Redirect coinciding with a response and a decode handshake (latency 2).
    do_reset();
    latency    = 2;
    inst_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      sample(); advance();
    end
    redirect_valid = 1'b1;
    redirect_pc    = 64'h2000;
    sample();
    check("coin_rsp_present", imem_rsp_valid, 1);
    check("coin_hs_valid",    inst_valid, 1);
    check("coin_hs_pc",       inst_pc, 64'h4);
    advance();
    redirect_valid = 1'b0;
    sample();
    check("coin_queue_empty", inst_valid, 0);
    check("coin_drop",        dut.drop, 1);
    advance();
    for (int i = 0; i < 10; i++) begin
      sample(); advance();
    end
    check("coin_hs_count", hs_pc.size() >= 3, 1);
    if (hs_pc.size() >= 3) begin
      check("coin_delivered", hs_pc[1], 64'h4);
      check("coin_new_pc",    hs_pc[2], 64'h2000);
    end

    // PC wraps modulo 2^64.
    do_reset();
    inst_ready     = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 64'hFFFF_FFFF_FFFF_FFFF;
    sample(); advance();
    redirect_valid = 1'b0;
    sample();
    check("wrap_addr_top", imem_req_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    advance();
    sample();
    check("wrap_addr_zero", imem_req_addr, 64'h0);
    advance();
    for (int i = 0; i < 6; i++) begin
      sample(); advance();
    end
    check("wrap_hs_count", hs_pc.size() >= 2, 1);
    if (hs_pc.size() >= 2) begin
      check("wrap_pc0", hs_pc[0], 64'hFFFF_FFFF_FFFF_FFFC);
      check("wrap_pc1", hs_pc[1], 64'h0);
    end

    // Stray response sets the sticky error; reset mid-stream clears everything at once.
    do_reset();
    imem_req_ready = 1'b0;
    force_rsp      = 1'b1;
    sample(); advance();
    force_rsp = 1'b0;
    sample();
    check("stray_err",        rsp_err, 1);
    check("stray_queue",      inst_valid, 0);
    advance();
    for (int i = 0; i < 3; i++) begin
      sample(); advance();
    end
    sample();
    check("stray_err_sticky", rsp_err, 1);
    advance();
    imem_req_ready = 1'b1;
    inst_ready     = 1'b1;
    for (int i = 0; i < 5; i++) begin
      sample(); advance();
    end
    sample();
    check("pre_reset_inst_valid", inst_valid, 1);
    reset = 1'b0;
    #1;
    check("mid_rst_req_valid",  imem_req_valid, 0);
    check("mid_rst_req_addr",   imem_req_addr, 0);
    check("mid_rst_inst_valid", inst_valid, 0);
    check("mid_rst_inst_pc",    inst_pc, 0);
    check("mid_rst_inst_data",  inst_data, 0);
    check("mid_rst_rsp_err",    rsp_err, 0);
    mq_addr.delete();
    mq_due.delete();
    @(negedge clk);
    reset = 1'b1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
